// File: rtl/register_file_ff_param.sv
// Flop-based register file: 3 combinational read ports, 2 write ports.
// Includes a background sweep-clear engine and optional write bypass.
module register_file_ff_param #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_cg_en_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  we_a_i,
  input  logic                  we_b_i,
  input  logic                  clr_req_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic                  wr_drop_o
);

  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic clearing;
  logic wr_a_ok;
  logic wr_b_ok;
  logic unused_scan;

  assign unused_scan = scan_cg_en_i;

  assign clearing = (state_q == ST_CLEAR);

  assign wr_a_ok = we_a_i && !clearing &&
                   !(ZERO_REG && (waddr_a_i == '0));
  assign wr_b_ok = we_b_i && !clearing &&
                   !(ZERO_REG && (waddr_b_i == '0));

  assign clr_busy_o = clearing;
  assign clr_done_o = (state_q == ST_DONE);
  assign wr_drop_o  = clearing && (we_a_i || we_b_i);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // ptr wraps to 0 naturally on the last word
        ptr_d = ptr_q + PTR_ONE;
        if (&ptr_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Port B is assigned last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clearing) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr_a_ok) begin
        mem_q[waddr_a_i] <= wdata_a_i;
      end
      if (wr_b_ok) begin
        mem_q[waddr_b_i] <= wdata_b_i;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] v;
    v = mem_q[addr];
    if (BYPASS && !clearing) begin
      if (we_b_i && (waddr_b_i == addr)) begin
        v = wdata_b_i;
      end else if (we_a_i && (waddr_a_i == addr)) begin
        v = wdata_a_i;
      end
    end
    if (!rst_n || (ZERO_REG && (addr == '0))) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    rdata_a_o = rd_port(raddr_a_i);
    rdata_b_o = rd_port(raddr_b_i);
    rdata_c_o = rd_port(raddr_c_i);
  end

endmodule

// File: tb/tb_register_file_ff_param.sv
// Bench for register_file_ff_param: default instance plus a
// ZERO_REG=0 / BYPASS=1 instance sharing the same stimulus.
module tb_register_file_ff_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_cg_en = 1'b0;
  logic [4:0]  raddr_a, raddr_b, raddr_c;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, clr_req;

  logic [31:0] rd0_a, rd0_b, rd0_c;
  logic [31:0] rd1_a, rd1_b, rd1_c;
  logic        busy0, done0, drop0;
  logic        busy1, done1, drop1;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    int          d;
    int          p;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  always #5 clk = ~clk;

  register_file_ff_param dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_cg_en_i (scan_cg_en),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .raddr_c_i    (raddr_c),
    .rdata_a_o    (rd0_a),
    .rdata_b_o    (rd0_b),
    .rdata_c_o    (rd0_c),
    .waddr_a_i    (waddr_a),
    .waddr_b_i    (waddr_b),
    .wdata_a_i    (wdata_a),
    .wdata_b_i    (wdata_b),
    .we_a_i       (we_a),
    .we_b_i       (we_b),
    .clr_req_i    (clr_req),
    .clr_busy_o   (busy0),
    .clr_done_o   (done0),
    .wr_drop_o    (drop0)
  );

  register_file_ff_param #(
    .ZERO_REG (1'b0),
    .BYPASS   (1'b1)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_cg_en_i (scan_cg_en),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .raddr_c_i    (raddr_c),
    .rdata_a_o    (rd1_a),
    .rdata_b_o    (rd1_b),
    .rdata_c_o    (rd1_c),
    .waddr_a_i    (waddr_a),
    .waddr_b_i    (waddr_b),
    .wdata_a_i    (wdata_a),
    .wdata_b_i    (wdata_b),
    .we_a_i       (we_a),
    .we_b_i       (we_b),
    .clr_req_i    (clr_req),
    .clr_busy_o   (busy1),
    .clr_done_o   (done1),
    .wr_drop_o    (drop1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_out(input int d, input int p);
    if (d == 0) begin
      if (p == 0) return rd0_a;
      if (p == 1) return rd0_b;
      if (p == 2) return rd0_c;
      return 32'(drop0);
    end
    if (p == 0) return rd1_a;
    if (p == 1) return rd1_b;
    if (p == 2) return rd1_c;
    return 32'(drop1);
  endfunction

  // dut0: zero register, no bypass; dut1: no zero reg, bypass
  function automatic logic [31:0] mdl_rd(
    input int       d,
    input logic [4:0] a,
    input bit       in_clear
  );
    if (!rst_n) return 32'h0;
    if (d == 0) return (a == 5'd0) ? 32'h0 : m0[a];
    if (!in_clear) begin
      if (we_b && waddr_b == a) return wdata_b;
      if (we_a && waddr_a == a) return wdata_a;
    end
    return m1[a];
  endfunction

  task automatic drive_cycle(
    input string       tag,
    input logic        wea,
    input logic [4:0]  wa,
    input logic [31:0] da,
    input logic        web,
    input logic [4:0]  wb,
    input logic [31:0] db,
    input logic [4:0]  ra,
    input logic [4:0]  rb,
    input logic [4:0]  rc,
    input logic        clr,
    input bit          in_clear
  );
    logic [4:0] ad;
    sb_t        e;
    we_a = wea; waddr_a = wa; wdata_a = da;
    we_b = web; waddr_b = wb; wdata_b = db;
    raddr_a = ra; raddr_b = rb; raddr_c = rc;
    clr_req = clr;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 3; p++) begin
        ad = (p == 0) ? ra : ((p == 1) ? rb : rc);
        sbq.push_back('{tag, d, p, mdl_rd(d, ad, in_clear)});
      end
      sbq.push_back('{tag, d, 3,
        32'(rst_n && in_clear && (wea || web))});
    end
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("%s.d%0d.p%0d", e.tag, e.d, e.p),
          dut_out(e.d, e.p), e.exp);
    end
    if (rst_n && !in_clear) begin
      if (wea && wa != 5'd0) m0[wa] = da;
      if (web && wb != 5'd0) m0[wb] = db;
      if (wea) m1[wa] = da;
      if (web) m1[wb] = db;
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] ra,
                    input logic [4:0] rb, input logic [4:0] rc);
    drive_cycle(tag, 0, 0, 0, 0, 0, 0, ra, rb, rc, 0, 0);
  endtask

  task automatic chk_flags(input string tag, input bit eb,
                           input bit ed);
    chk({tag, ".busy0"}, 32'(busy0), 32'(eb));
    chk({tag, ".busy1"}, 32'(busy1), 32'(eb));
    chk({tag, ".done0"}, 32'(done0), 32'(ed));
    chk({tag, ".done1"}, 32'(done1), 32'(ed));
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 32'h0;
      m1[i] = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_models();
    we_a = 0; we_b = 0; clr_req = 0;
    waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0;
    raddr_a = 0; raddr_b = 0; raddr_c = 0;

    // reset holds outputs at 0 even with a bypassable write
    @(negedge clk);
    drive_cycle("rst", 1, 3, 32'hCAFE0000, 1, 4, 32'h1,
                3, 4, 0, 0, 0);
    chk_flags("rst", 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    rd("rel", 3, 4, 0);
    chk_flags("rel", 0, 0);

    @(negedge clk);
    drive_cycle("wr5", 1, 5, 32'hDEADBEEF, 0, 0, 0,
                5, 5, 5, 0, 0);
    @(negedge clk);
    rd("rd5", 5, 5, 5);

    @(negedge clk);
    drive_cycle("col", 1, 7, 32'h11111111, 1, 7, 32'h22222222,
                7, 7, 7, 0, 0);
    @(negedge clk);
    rd("rd7", 7, 7, 7);

    @(negedge clk);
    drive_cycle("wz", 1, 0, 32'hFFFFFFFF, 0, 0, 0,
                1, 1, 1, 0, 0);
    @(negedge clk);
    rd("rz", 0, 0, 0);

    @(negedge clk);
    drive_cycle("byp", 1, 3, 32'hCAFE0001, 0, 0, 0,
                0, 3, 3, 0, 0);
    @(negedge clk);
    drive_cycle("bpri", 1, 9, 32'hAAAA0009, 1, 9, 32'hBBBB0009,
                9, 9, 3, 0, 0);
    @(negedge clk);
    rd("rdb", 3, 9, 7);

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive_cycle("pre", 1, 5'(2 * k), 32'hA5A5A5A5,
                  1, 5'(2 * k + 1), 32'hA5A5A5A5,
                  5'(2 * k), 5'(2 * k + 1), 5, 0, 0);
    end

    @(negedge clk);
    drive_cycle("req", 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0);
    chk_flags("req", 0, 0);

    // word c is still intact in sweep cycle c, word c-1 is already 0
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      drive_cycle($sformatf("swp%0d", c), (c == 12), 5,
                  32'h00001234, 0, 0, 0,
                  5'(c), 5'(c - 1), 5, 0, (c < 32));
      chk_flags($sformatf("swp%0d", c), (c < 32), (c == 32));
      if (c < 32) begin
        m0[c] = 32'h0;
        m1[c] = 32'h0;
      end
    end

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rd("clr", 5'(3 * k), 5'(3 * k + 1), 5'(3 * k + 2));
    end

    @(negedge clk);
    drive_cycle("pre2", 1, 30, 32'h30303030, 1, 31, 32'h31313131,
                30, 31, 0, 0, 0);
    @(negedge clk);
    drive_cycle("req2", 0, 0, 0, 0, 0, 0, 30, 31, 0, 1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rd("pre_rst", 30, 5'(c), 31);
      chk_flags("pre_rst", 1, 0);
      m0[c] = 32'h0;
      m1[c] = 32'h0;
    end
    @(negedge clk);
    drive_cycle("pre_rst10", 0, 0, 0, 0, 0, 0, 30, 31, 10, 0, 1);
    chk_flags("pre_rst10", 1, 0);

    #2;
    rst_n = 1'b0;
    zero_models();
    drive_cycle("rstmid", 1, 30, 32'h77, 0, 0, 0,
                30, 31, 30, 1, 0);
    chk_flags("rstmid", 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    rd("post", 30, 31, 20);
    chk_flags("post", 0, 0);
    @(negedge clk);
    drive_cycle("post_wr", 1, 4, 32'h44444444, 0, 0, 0,
                4, 30, 31, 0, 0);
    chk_flags("post_wr", 0, 0);
    @(negedge clk);
    rd("post_rd", 4, 30, 31);
    chk_flags("post_rd", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
